// File: rtl/mprj_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the user-project bus port.
// Optional slave watchdog is compiled in with `define MPRJ_WB_TIMEOUT_EN.
module mprj_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic        core_clk,
    input  logic        core_rst,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,

    output logic        mprj_cyc_o,
    output logic        mprj_stb_o,
    output logic        mprj_we_o,
    output logic [3:0]  mprj_sel_o,
    output logic [31:0] mprj_adr_o,
    output logic [31:0] mprj_dat_o,
    input  logic        mprj_ack_i,
    input  logic [31:0] mprj_dat_i,

    output logic        mprj_wb_iena,
    output logic [1:0]  grant_o,
    output logic        tmo_flag_o,
    input  logic        tmo_clr_i
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   ptr_q, ptr_d;     // 0: m0 wins a tie, 1: m1 wins a tie
    logic   term_q;           // watchdog termination cycle in progress
    logic   req0, req1;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Grant selection; ownership is held until the owner drops cyc.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (req0 && (!req1 || !ptr_q)) begin
                    state_d = S_GNT0;
                end else if (req1) begin
                    state_d = S_GNT1;
                end
            end
            S_GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = S_IDLE;
                    ptr_d   = 1'b1;
                end
            end
            S_GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = S_IDLE;
                    ptr_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o      = {state_q == S_GNT1, state_q == S_GNT0};
    assign mprj_wb_iena = (state_q != S_IDLE);

    // Route the owner onto the slave bus and return ack/data only to the owner.
    always_comb begin
        mprj_cyc_o = 1'b0;
        mprj_stb_o = 1'b0;
        mprj_we_o  = 1'b0;
        mprj_sel_o = 4'h0;
        mprj_adr_o = 32'h0;
        mprj_dat_o = 32'h0;
        m0_ack_o   = 1'b0;
        m0_dat_o   = 32'h0;
        m1_ack_o   = 1'b0;
        m1_dat_o   = 32'h0;
        if (grant_o[0]) begin
            mprj_cyc_o = m0_cyc_i & ~term_q;
            mprj_stb_o = m0_stb_i & ~term_q;
            mprj_we_o  = m0_we_i;
            mprj_sel_o = m0_sel_i;
            mprj_adr_o = m0_adr_i;
            mprj_dat_o = m0_dat_i;
            m0_ack_o   = mprj_ack_i | term_q;
            m0_dat_o   = term_q ? TIMEOUT_DATA : mprj_dat_i;
        end else if (grant_o[1]) begin
            mprj_cyc_o = m1_cyc_i & ~term_q;
            mprj_stb_o = m1_stb_i & ~term_q;
            mprj_we_o  = m1_we_i;
            mprj_sel_o = m1_sel_i;
            mprj_adr_o = m1_adr_i;
            mprj_dat_o = m1_dat_i;
            m1_ack_o   = mprj_ack_i | term_q;
            m1_dat_o   = term_q ? TIMEOUT_DATA : mprj_dat_i;
        end
    end

`ifdef MPRJ_WB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             term_d;
    logic             flag_q, flag_d;

    // Count unacknowledged strobe cycles; fire a one-cycle termination at the limit.
    always_comb begin
        cnt_d  = '0;
        term_d = 1'b0;
        if (mprj_stb_o && !mprj_ack_i && (state_d == state_q)) begin
            if (cnt_q == TMO_LAST) begin
                term_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        flag_d = term_d | (flag_q & ~tmo_clr_i);
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            cnt_q  <= '0;
            term_q <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
            flag_q <= flag_d;
        end
    end

    assign tmo_flag_o = flag_q;
`else
    logic unused_tmo;

    assign term_q     = 1'b0;
    assign tmo_flag_o = 1'b0;
    assign unused_tmo = ^{tmo_clr_i, CNT_W'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_mprj_wb_arbiter.sv
// Self-checking bench for mprj_wb_arbiter: directed scenarios plus randomized
// masters/slave checked every cycle against a rule-level reference model.
module tb_mprj_wb_arbiter;

    localparam int unsigned TMO   = 8;
    localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic        mcyc [2];
    logic        mstb [2];
    logic        mwe  [2];
    logic [3:0]  msel [2];
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        mprj_cyc_o, mprj_stb_o, mprj_we_o;
    logic [3:0]  mprj_sel_o;
    logic [31:0] mprj_adr_o, mprj_dat_o;
    logic        mprj_ack_i;
    logic [31:0] mprj_dat_i;
    logic        mprj_wb_iena;
    logic [1:0]  grant_o;
    logic        tmo_flag_o;
    logic        tmo_clr_i;

    mprj_wb_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_DATA  (TDATA)
    ) dut (
        .core_clk    (core_clk),
        .core_rst    (core_rst),
        .m0_cyc_i    (mcyc[0]),
        .m0_stb_i    (mstb[0]),
        .m0_we_i     (mwe[0]),
        .m0_sel_i    (msel[0]),
        .m0_adr_i    (madr[0]),
        .m0_dat_i    (mdat[0]),
        .m0_ack_o    (m0_ack_o),
        .m0_dat_o    (m0_dat_o),
        .m1_cyc_i    (mcyc[1]),
        .m1_stb_i    (mstb[1]),
        .m1_we_i     (mwe[1]),
        .m1_sel_i    (msel[1]),
        .m1_adr_i    (madr[1]),
        .m1_dat_i    (mdat[1]),
        .m1_ack_o    (m1_ack_o),
        .m1_dat_o    (m1_dat_o),
        .mprj_cyc_o  (mprj_cyc_o),
        .mprj_stb_o  (mprj_stb_o),
        .mprj_we_o   (mprj_we_o),
        .mprj_sel_o  (mprj_sel_o),
        .mprj_adr_o  (mprj_adr_o),
        .mprj_dat_o  (mprj_dat_o),
        .mprj_ack_i  (mprj_ack_i),
        .mprj_dat_i  (mprj_dat_i),
        .mprj_wb_iena(mprj_wb_iena),
        .grant_o     (grant_o),
        .tmo_flag_o  (tmo_flag_o),
        .tmo_clr_i   (tmo_clr_i)
    );

    always #5 core_clk = ~core_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner 0 = idle, 1 = m0, 2 = m1; fav = master winning a tie.
    int owner = 0;
    int fav   = 0;
    int run   = 0;
    bit term  = 1'b0;
    bit flag  = 1'b0;
    int nown;
    bit nt;
    bit e_stb;
    bit r0, r1;

    always @(posedge core_clk) begin
        if (core_rst) begin
            owner = 0; fav = 0; run = 0; term = 1'b0; flag = 1'b0;
        end else begin
            r0    = mcyc[0] && mstb[0];
            r1    = mcyc[1] && mstb[1];
            e_stb = !term && ((owner == 1 && mstb[0]) || (owner == 2 && mstb[1]));
            nown  = owner;
            if (owner == 0) begin
                if (r0 && (!r1 || fav == 0)) nown = 1;
                else if (r1)                 nown = 2;
            end else if (!mcyc[owner-1]) begin
                nown = 0;
                fav  = (owner == 1) ? 1 : 0;
            end
            nt = 1'b0;
`ifdef MPRJ_WB_TIMEOUT_EN
            // TMO consecutive unacknowledged strobe cycles under one owner -> terminate.
            if (e_stb && !mprj_ack_i && nown == owner) begin
                run++;
                if (run == TMO) begin
                    nt  = 1'b1;
                    run = 0;
                end
            end else begin
                run = 0;
            end
            flag = nt ? 1'b1 : (tmo_clr_i ? 1'b0 : flag);
`endif
            term  = nt;
            owner = nown;
        end
    end

    bit          g0, g1;
    logic [31:0] ev;

    // Per-cycle comparison of every output against the model.
    always @(negedge core_clk) begin
        g0 = (owner == 1);
        g1 = (owner == 2);
        chk("grant", 32'(grant_o), 32'({g1, g0}));
        chk("iena", 32'(mprj_wb_iena), 32'(g0 | g1));
        ev = g0 ? 32'(mcyc[0]) : g1 ? 32'(mcyc[1]) : 32'd0;
        chk("bus_cyc", 32'(mprj_cyc_o), term ? 32'd0 : ev);
        ev = g0 ? 32'(mstb[0]) : g1 ? 32'(mstb[1]) : 32'd0;
        chk("bus_stb", 32'(mprj_stb_o), term ? 32'd0 : ev);
        chk("bus_we",  32'(mprj_we_o),  g0 ? 32'(mwe[0])  : g1 ? 32'(mwe[1])  : 32'd0);
        chk("bus_sel", 32'(mprj_sel_o), g0 ? 32'(msel[0]) : g1 ? 32'(msel[1]) : 32'd0);
        chk("bus_adr", mprj_adr_o, g0 ? madr[0] : g1 ? madr[1] : 32'd0);
        chk("bus_dat", mprj_dat_o, g0 ? mdat[0] : g1 ? mdat[1] : 32'd0);
        chk("m0_ack", 32'(m0_ack_o), 32'(g0 && (term || mprj_ack_i)));
        chk("m1_ack", 32'(m1_ack_o), 32'(g1 && (term || mprj_ack_i)));
        chk("m0_dat", m0_dat_o, g0 ? (term ? TDATA : mprj_dat_i) : 32'd0);
        chk("m1_dat", m1_dat_o, g1 ? (term ? TDATA : mprj_dat_i) : 32'd0);
        chk("tmo_flag", 32'(tmo_flag_o), 32'(flag));
    end

    // Observations used by the bus-functional masters/slave and grant history.
    logic       last_ack0 = 1'b0, last_ack1 = 1'b0, last_stb = 1'b0, last_sack = 1'b0;
    logic [1:0] prev_grant = 2'b00;
    logic [1:0] gq[$];

    always @(negedge core_clk) begin
        last_ack0 <= m0_ack_o;
        last_ack1 <= m1_ack_o;
        last_stb  <= mprj_stb_o;
        last_sack <= mprj_ack_i;
        if (grant_o != 2'b00 && prev_grant == 2'b00) gq.push_back(grant_o);
        prev_grant <= grant_o;
    end

    int act  [2] = '{0, 0};
    int left [2] = '{0, 0};
    int want [2] = '{0, 0};
    int blen [2] = '{0, 0};
    int gap_pct   = 0;
    int slave_pct = 100;

    task automatic step_clk();
        @(posedge core_clk);
        #1;
    endtask

    task automatic new_beat(input int x);
        mwe[x]  = 1'($urandom_range(1));
        msel[x] = 4'($urandom_range(15));
        madr[x] = 32'h3000_0000 | 32'($urandom_range(255) << 2);
        mdat[x] = $urandom;
    endtask

    // One cycle of master and slave behaviour driven from last cycle's observations.
    task automatic auto_step();
        logic seen;
        for (int x = 0; x < 2; x++) begin
            seen = (x == 0) ? last_ack0 : last_ack1;
            if (act[x] != 0) begin
                if (seen) begin
                    left[x]--;
                    if (left[x] == 0) begin
                        act[x]  = 0;
                        mcyc[x] = 1'b0;
                        mstb[x] = 1'b0;
                    end else begin
                        new_beat(x);
                    end
                end
            end else if (want[x] > 0 && int'($urandom_range(99)) >= gap_pct) begin
                act[x]  = 1;
                left[x] = (blen[x] != 0) ? blen[x] : int'($urandom_range(4, 1));
                want[x]--;
                mcyc[x] = 1'b1;
                mstb[x] = 1'b1;
                new_beat(x);
            end
        end
        mprj_ack_i = last_stb && !last_sack && (int'($urandom_range(99)) < slave_pct);
        mprj_dat_i = $urandom;
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n;
        bit expired;
        n = 0;
        expired = 1'b1;
        while (n < budget) begin
            auto_step();
            @(negedge core_clk);
            if (want[0] == 0 && want[1] == 0 && act[0] == 0 && act[1] == 0 && grant_o == 2'b00) begin
                expired = 1'b0;
                break;
            end
            step_clk();
            n++;
        end
        chk(name, 32'(expired), 32'd0);
        step_clk();
        mprj_ack_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    int rel, gfirst, drops;
    bit seen1;

    initial begin
        core_rst   = 1'b1;
        mprj_ack_i = 1'b0;
        mprj_dat_i = 32'h0;
        tmo_clr_i  = 1'b0;
        for (int x = 0; x < 2; x++) begin
            mcyc[x] = 1'b0; mstb[x] = 1'b0; mwe[x] = 1'b0;
            msel[x] = 4'h0; madr[x] = 32'h0; mdat[x] = 32'h0;
        end
        repeat (2) @(posedge core_clk);
        #1;
        core_rst = 1'b0;
        @(negedge core_clk);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_iena", 32'(mprj_wb_iena), 32'd0);
        chk("rst_flag", 32'(tmo_flag_o), 32'd0);

        // Single m0 read, slave acks two cycles after the strobe reaches it.
        step_clk();
        mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0; msel[0] = 4'hF;
        madr[0] = 32'h3000_0004;
        @(negedge core_clk);
        chk("t1_stb_req_cycle", 32'(mprj_stb_o), 32'd0);
        step_clk();
        @(negedge core_clk);
        chk("t1_stb_next", 32'(mprj_stb_o), 32'd1);
        chk("t1_adr", mprj_adr_o, 32'h3000_0004);
        chk("t1_grant", 32'(grant_o), 32'd1);
        step_clk();
        step_clk();
        mprj_ack_i = 1'b1; mprj_dat_i = 32'h1234_5678;
        @(negedge core_clk);
        chk("t1_m0_ack", 32'(m0_ack_o), 32'd1);
        chk("t1_m0_dat", m0_dat_o, 32'h1234_5678);
        chk("t1_m1_ack", 32'(m1_ack_o), 32'd0);
        step_clk();
        mprj_ack_i = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0;
        step_clk();
        @(negedge core_clk);
        chk("t1_grant_idle", 32'(grant_o), 32'd0);

        // Simultaneous one-beat writes after reset: m0 first, then m1.
        step_clk();
        core_rst = 1'b1;
        step_clk();
        core_rst = 1'b0;
        mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b1; mdat[0] = 32'hA0A0_0000;
        mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b1; mdat[1] = 32'hB1B1_0001;
        step_clk();
        mprj_ack_i = 1'b1;
        @(negedge core_clk);
        chk("t2_first_grant", 32'(grant_o), 32'd1);
        chk("t2_wdat0", mprj_dat_o, 32'hA0A0_0000);
        step_clk();
        mprj_ack_i = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0;
        step_clk();
        @(negedge core_clk);
        chk("t2_gap_grant", 32'(grant_o), 32'd0);
        step_clk();
        mprj_ack_i = 1'b1;
        @(negedge core_clk);
        chk("t2_second_grant", 32'(grant_o), 32'd2);
        chk("t2_wdat1", mprj_dat_o, 32'hB1B1_0001);
        step_clk();
        mprj_ack_i = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
        step_clk();
        step_clk();

        // Continuous single-beat requests from both: grants must alternate.
        gq.delete();
        slave_pct = 100; gap_pct = 0;
        want[0] = 3; want[1] = 3; blen[0] = 1; blen[1] = 1;
        run_until_idle(200, "t3_idle");
        chk("t3_count", 32'(gq.size()), 32'd6);
        for (int i = 0; i < 6 && i < gq.size(); i++)
            chk($sformatf("t3_order_%0d", i), 32'(gq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

        // m1 4-beat burst holds the bus while m0 waits.
        want[1] = 1; blen[1] = 4;
        auto_step();
        @(negedge core_clk);
        step_clk();
        want[0] = 1; blen[0] = 1;
        rel = -1; gfirst = -1; drops = 0; seen1 = 1'b0;
        for (int i = 0; i < 80; i++) begin
            auto_step();
            @(negedge core_clk);
            if (grant_o == 2'b10) seen1 = 1'b1;
            if (grant_o == 2'b10 && mcyc[1] && !mprj_cyc_o) drops++;
            if (seen1 && rel < 0 && !mcyc[1]) rel = i;
            if (gfirst < 0 && grant_o == 2'b01) gfirst = i;
            if (want[0] == 0 && act[0] == 0 && act[1] == 0 && grant_o == 2'b00) break;
            step_clk();
        end
        step_clk();
        mprj_ack_i = 1'b0;
        chk("t4_m1_first", 32'(seen1), 32'd1);
        chk("t4_no_drop", 32'(drops), 32'd0);
        chk("t4_m0_latency", 32'(gfirst - rel), 32'd2);

        // Reset during an m1 transfer awaiting ack.
        mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h3000_0100;
        step_clk();
        step_clk();
        step_clk();
        core_rst = 1'b1;
        @(negedge core_clk);
        chk("t5_pre_rst_grant", 32'(grant_o), 32'd2);
        step_clk();
        core_rst = 1'b0; mprj_ack_i = 1'b1;
        mcyc[0] = 1'b1; mstb[0] = 1'b1;
        @(negedge core_clk);
        chk("t5_grant", 32'(grant_o), 32'd0);
        chk("t5_bus_cyc", 32'(mprj_cyc_o), 32'd0);
        chk("t5_late_ack", 32'(m1_ack_o), 32'd0);
        step_clk();
        mprj_ack_i = 1'b0;
        @(negedge core_clk);
        chk("t5_m0_wins", 32'(grant_o), 32'd1);
        step_clk();
        mcyc[0] = 1'b0; mstb[0] = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
        repeat (3) step_clk();

`ifdef MPRJ_WB_TIMEOUT_EN
        // Slave never acks: watchdog terminates after TMO stall cycles.
        mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step_clk();
            @(negedge core_clk);
            chk($sformatf("t6_stall_%0d", k), 32'({mprj_stb_o, m0_ack_o}), 32'b10);
        end
        step_clk();
        @(negedge core_clk);
        chk("t6_term_ack", 32'(m0_ack_o), 32'd1);
        chk("t6_term_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("t6_term_stb", 32'(mprj_stb_o), 32'd0);
        chk("t6_flag_set", 32'(tmo_flag_o), 32'd1);
        step_clk();
        mcyc[0] = 1'b0; mstb[0] = 1'b0;
        @(negedge core_clk);
        chk("t6_flag_sticky", 32'(tmo_flag_o), 32'd1);
        step_clk();
        tmo_clr_i = 1'b1;
        step_clk();
        tmo_clr_i = 1'b0;
        @(negedge core_clk);
        chk("t6_flag_clr", 32'(tmo_flag_o), 32'd0);
        repeat (2) step_clk();
`endif

        // Randomized traffic with occasional flag clears and resets.
        slave_pct = 50; gap_pct = 30;
        want[0] = 400; want[1] = 400; blen[0] = 0; blen[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            auto_step();
            tmo_clr_i = ($urandom_range(19) == 0);
            core_rst  = ($urandom_range(299) == 0);
            @(negedge core_clk);
            step_clk();
        end
        want[0] = 0; want[1] = 0;
        tmo_clr_i = 1'b0; core_rst = 1'b0;
        run_until_idle(400, "rand_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mprj_wb_arbiter.md
Name: mprj_wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter for the user-project (mprj) bus port of the management SoC.
- Master 0 is the management CPU. Master 1 is a secondary requester, such as the NPU DMA or debug bridge.
- The block round-robins grants, routes ack and read data only to the granted master, and drives mprj_wb_iena.
- An optional watchdog terminates slave transactions that never acknowledge.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted strobe may wait without ack before the watchdog terminates it (range 2..65535).
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned to the master on a watchdog termination.

Ports:
- core_clk  in  1  system clock; all logic is on its rising edge.
- core_rst  in  1  synchronous reset, active-high.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe and write enable.
- m0_sel_i  in  4  master 0 byte selects.
- m0_adr_i, m0_dat_i  in  32 each  master 0 address and write data.
- m0_ack_o  out  1  ack to master 0.
- m0_dat_o  out  32  read data to master 0.
- m1_*  same set as m0_*  master 1.
- mprj_cyc_o, mprj_stb_o, mprj_we_o  out  1 each  to the user-project slave.
- mprj_sel_o  out  4  to the slave.
- mprj_adr_o, mprj_dat_o  out  32 each  to the slave.
- mprj_ack_i  in  1  slave ack.
- mprj_dat_i  in  32  slave read data.
- mprj_wb_iena  out  1  enables the user-side return signals; high while any grant is held.
- grant_o  out  2  one-hot current owner; 2'b00 when idle.
- tmo_flag_o  out  1  sticky watchdog-fired flag.
- tmo_clr_i  in  1  clears tmo_flag_o.

Behaviour:
- Reset values: grant_o=00, all mprj_* outputs 0, mprj_wb_iena=0, m0/m1 ack=0 and dat=0, tmo_flag_o=0, round-robin pointer favours m0, watchdog counter=0.
- States:
  - IDLE → GNT0 when req0=cyc&stb of m0 and only m0 requests, or both request and the pointer favours m0.
  - IDLE → GNT1 symmetrically.
  - GNTx → IDLE on the cycle after mx_cyc_i samples low.
- Grant is registered, so a new request reaches the slave 1 cycle after it is first presented. Back-to-back strobes within one held cyc incur no extra latency.
- While in GNTx:
  - mprj_{cyc,stb,we,sel,adr,dat}_o = mx inputs (combinational) gated by grant_o[x].
  - mx_ack_o = mprj_ack_i.
  - mx_dat_o = mprj_dat_i.
  - The non-granted master sees ack=0, dat=0.
- The bus is locked for the whole cyc burst, and the other master stalls.
- The pointer flips to the other master on every release from GNTx. This guarantees fairness: with both requesting continuously, grants alternate m0, m1, m0, and so on.
- In IDLE, all mprj outputs are 0, so the slave never sees a stale strobe.
- If the granted master drops cyc in the same cycle the slave acks, the ack is still forwarded and the state returns to IDLE next cycle.
- If core_rst is asserted mid-transfer, all outputs return to reset values on the next edge. An outstanding slave ack is ignored, and the pointer resets to favour m0.
- Simultaneous tmo_clr_i and a watchdog fire: the fire wins and the flag stays 1.

Optional Feature:
- Macro: MPRJ_WB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter increments each cycle that mprj_stb_o=1 and mprj_ack_i=0. It clears on ack, on stb low, or on grant change.
  - When the counter reaches TIMEOUT_CYCLES-1 without an ack, the next cycle is a termination cycle:
    - mx_ack_o=1 and mx_dat_o=TIMEOUT_DATA.
    - mprj_cyc_o and mprj_stb_o are forced 0 for that cycle.
    - tmo_flag_o is set and remains set until tmo_clr_i.
    - The counter clears.
- When undefined: there is no counter, tmo_flag_o is tied 0, tmo_clr_i is ignored, and a non-acking slave hangs the bus indefinitely.

Test Plan:
- Single m0 read of adr 0x3000_0004; slave acks 2 cycles after stb with 0x1234_5678 → mprj_stb_o rises 1 cycle after request, m0_ack_o=1 and m0_dat_o=0x1234_5678 in the same cycle as mprj_ack_i, m1_ack_o=0 throughout, grant_o=01 during the transfer and then 00.
- m0 and m1 request in the same cycle after reset, each doing a one-beat write → m0 is served first, m1 second, grant_o sequence 01, 00, 10.
- Both hold continuous single-beat requests for 6 transactions → grants strictly alternate m0, m1, m0, m1, m0, m1.
- m1 holds cyc for a 4-beat burst while m0 requests → m0 is stalled until m1 releases cyc; m0 is granted 2 cycles after release; mprj_cyc_o never deasserts mid-burst.
- core_rst pulsed for 1 cycle during an m1 transfer awaiting ack → next cycle grant_o=00, mprj_cyc_o=0, a late mprj_ack_i is not forwarded, and the next simultaneous request goes to m0.
- With MPRJ_WB_TIMEOUT_EN and TIMEOUT_CYCLES=8, m0 reads from a slave that never acks → after 8 stall cycles m0_ack_o=1 with m0_dat_o=0xDEAD_BEEF, mprj_stb_o=0 that cycle, tmo_flag_o=1 until a tmo_clr_i pulse, after which it reads 0.
